// File: rtl/uart_rx_fsm_if.sv
`default_nettype none
// uart_rx_fsm_if: signal bundle between the UART receive control FSM and its datapath/checkers.
// Rev 1.0
interface uart_rx_fsm_if #(
  parameter int PRESCALE_W = 6
);
  logic                  rx_in;
  logic [PRESCALE_W-1:0] prescale;
  logic                  par_en;
  logic                  strt_glitch;
  logic                  par_err;
  logic                  stp_err;
  logic [PRESCALE_W-1:0] edge_cnt;
  logic [3:0]            bit_cnt;
  logic                  dat_samp_en;
  logic                  strt_chk_en;
  logic                  par_chk_en;
  logic                  stp_chk_en;
  logic                  deser_en;
  logic                  data_valid;
  logic                  frame_err;
  logic                  parity_err;

  modport master (
    input  rx_in, prescale, par_en, strt_glitch, par_err, stp_err,
    output edge_cnt, bit_cnt, dat_samp_en, strt_chk_en, par_chk_en, stp_chk_en,
           deser_en, data_valid, frame_err, parity_err
  );

  modport slave (
    output rx_in, prescale, par_en, strt_glitch, par_err, stp_err,
    input  edge_cnt, bit_cnt, dat_samp_en, strt_chk_en, par_chk_en, stp_chk_en,
           deser_en, data_valid, frame_err, parity_err
  );
endinterface
`default_nettype wire

// File: rtl/uart_rx_fsm.sv
`default_nettype none
// uart_rx_fsm: UART receive control FSM with oversampling edge/bit counters and result pulses.
// Rev 1.0
module uart_rx_fsm #(
  parameter int DATA_W     = 8,
  parameter int PRESCALE_W = 6
) (
  input  wire logic     clk,
  input  wire logic     rst_n,
  uart_rx_fsm_if.master bus
);
  localparam logic [PRESCALE_W-1:0] c_one       = PRESCALE_W'(1);
  localparam logic [PRESCALE_W-1:0] c_two       = PRESCALE_W'(2);
  localparam logic [PRESCALE_W-1:0] c_min_p     = PRESCALE_W'(4);
  localparam logic [PRESCALE_W-1:0] c_reset_p   = PRESCALE_W'(8);
  localparam logic [3:0]            c_last_data = 4'(DATA_W);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [PRESCALE_W-1:0] r_edge;
  logic [PRESCALE_W-1:0] r_p;
  logic [PRESCALE_W-1:0] w_p_even;
  logic [PRESCALE_W-1:0] w_p_new;
  logic [3:0]            r_bit;
  logic                  r_perr;
  logic                  r_dv;
  logic                  r_fe;
  logic                  r_pe;
  logic                  w_last;
  logic                  w_mid;
  logic                  w_samp;
  logic                  w_strt;
  logic                  w_deser;
  logic                  w_par;
  logic                  w_stp;

  // Odd ratios are rounded down so the mid-bit decode stays symmetric.
  assign w_p_even = {bus.prescale[PRESCALE_W-1:1], 1'b0};
  assign w_p_new  = (w_p_even < c_min_p) ? c_min_p : w_p_even;
  assign w_last   = (r_edge == (r_p - c_one));
  assign w_mid    = (r_edge == (r_p - c_two));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_samp  = 1'b0;
    w_strt  = 1'b0;
    w_deser = 1'b0;
    w_par   = 1'b0;
    w_stp   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!bus.rx_in) w_next = S_START;
      end
      S_START: begin
        w_samp = 1'b1;
        w_strt = w_mid;
        if (w_last) w_next = bus.strt_glitch ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        w_samp  = 1'b1;
        w_deser = w_mid;
        if (w_last && (r_bit == c_last_data)) w_next = bus.par_en ? S_PARITY : S_STOP;
      end
      S_PARITY: begin
        w_samp = 1'b1;
        w_par  = w_mid;
        if (w_last) w_next = S_STOP;
      end
      S_STOP: begin
        w_samp = 1'b1;
        w_stp  = w_mid;
        if (w_last) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // The IDLE->START cycle is edge 0 of the start bit, so counting resumes at 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_edge <= '0;
      r_bit  <= 4'd0;
      r_p    <= c_reset_p;
    end else if (r_state == S_IDLE) begin
      r_bit <= 4'd0;
      if (!bus.rx_in) begin
        r_edge <= c_one;
        r_p    <= w_p_new;
      end else begin
        r_edge <= '0;
      end
    end else if (w_next == S_IDLE) begin
      r_edge <= '0;
      r_bit  <= 4'd0;
    end else if (w_last) begin
      r_edge <= '0;
      r_bit  <= r_bit + 4'd1;
    end else begin
      r_edge <= r_edge + c_one;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perr <= 1'b0;
      r_dv   <= 1'b0;
      r_fe   <= 1'b0;
      r_pe   <= 1'b0;
    end else begin
      r_dv <= 1'b0;
      r_fe <= 1'b0;
      r_pe <= 1'b0;
      if ((r_state == S_PARITY) && w_last) r_perr <= bus.par_err;
      if ((r_state == S_STOP) && w_last) begin
        r_dv   <= !bus.stp_err && !r_perr;
        r_fe   <= bus.stp_err;
        r_pe   <= r_perr;
        r_perr <= 1'b0;
      end
    end
  end

  assign bus.edge_cnt    = r_edge;
  assign bus.bit_cnt     = r_bit;
  assign bus.dat_samp_en = w_samp;
  assign bus.strt_chk_en = w_strt;
  assign bus.deser_en    = w_deser;
  assign bus.par_chk_en  = w_par;
  assign bus.stp_chk_en  = w_stp;
  assign bus.data_valid  = r_dv;
  assign bus.frame_err   = r_fe;
  assign bus.parity_err  = r_pe;
endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fsm.sv
`default_nettype none
// tb_uart_rx_fsm: randomized frames checked cycle by cycle against a frame-timing model.
// Rev 1.0
module tb_uart_rx_fsm;
  localparam int DATA_W = 8;
  localparam int PW     = 6;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_rx_fsm_if #(.PRESCALE_W(PW)) bus ();

  uart_rx_fsm #(.DATA_W(DATA_W), .PRESCALE_W(PW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total    = 0;
  int bad      = 0;
  int frame_no = 0;
  bit pend_dv  = 1'b0;
  bit pend_fe  = 1'b0;
  bit pend_pe  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] observe();
    return {14'd0, bus.edge_cnt, bus.bit_cnt, bus.dat_samp_en, bus.strt_chk_en,
            bus.deser_en, bus.par_chk_en, bus.stp_chk_en,
            bus.data_valid, bus.frame_err, bus.parity_err};
  endfunction

  function automatic logic [31:0] pack(input int ec, input int bc, input bit samp,
                                       input bit strt, input bit des, input bit par,
                                       input bit stp, input bit dv, input bit fe,
                                       input bit pe);
    return {14'd0, 6'(ec), 4'(bc), samp, strt, des, par, stp, dv, fe, pe};
  endfunction

  // Inputs the FSM must ignore at this point get random values.
  task automatic noise();
    bus.prescale    = 6'($urandom);
    bus.par_en      = 1'($urandom);
    bus.strt_glitch = 1'($urandom);
    bus.par_err     = 1'($urandom);
    bus.stp_err     = 1'($urandom);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk($sformatf("idle f%0d", frame_no), observe(),
          pack(0, 0, 0, 0, 0, 0, 0, pend_dv, pend_fe, pend_pe));
      pend_dv = 1'b0;
      pend_fe = 1'b0;
      pend_pe = 1'b0;
      noise();
      bus.rx_in = 1'b1;
    end
  endtask

  // Frame cycle c=0 is the IDLE cycle in which rx_in is seen low.
  task automatic run_frame(input int psc, input bit pen, input bit g, input bit pe,
                           input bit se, input int abort_c);
    int p, nb, f, b, e;
    logic [DATA_W-1:0] d;
    logic [31:0] exp;
    p = psc & -2;
    if (p < 4) p = 4;
    nb = 2 + DATA_W + (pen ? 1 : 0);
    f  = g ? p : nb * p;
    d  = DATA_W'($urandom);
    for (int c = 0; c < f; c++) begin
      @(negedge clk);
      b = c / p;
      e = c % p;
      if (c == 0)
        exp = pack(0, 0, 0, 0, 0, 0, 0, pend_dv, pend_fe, pend_pe);
      else
        exp = pack(e, b, 1'b1, (b == 0) && (e == p - 2),
                   (b >= 1) && (b <= DATA_W) && (e == p - 2),
                   pen && (b == DATA_W + 1) && (e == p - 2),
                   (b == nb - 1) && (e == p - 2), 1'b0, 1'b0, 1'b0);
      chk($sformatf("f%0d c%0d p%0d", frame_no, c, p), observe(), exp);
      pend_dv = 1'b0;
      pend_fe = 1'b0;
      pend_pe = 1'b0;
      noise();
      if (b == 0)                      bus.rx_in = 1'b0;
      else if (b <= DATA_W)            bus.rx_in = d[b-1];
      else if (pen && b == DATA_W + 1) bus.rx_in = ^d;
      else                             bus.rx_in = 1'b1;
      if (c == 0)                                 bus.prescale    = 6'(psc);
      if (c == (DATA_W + 1) * p - 1)              bus.par_en      = pen;
      if (c == p - 1)                             bus.strt_glitch = g;
      if (pen && (c == (DATA_W + 2) * p - 1))     bus.par_err     = pe;
      if (c == nb * p - 1)                        bus.stp_err     = se;
      if (c == abort_c) begin
        #2 rst_n = 1'b0;
        #1 chk($sformatf("async rst f%0d", frame_no), observe(), 32'd0);
        bus.rx_in = 1'b1;
        @(negedge clk);
        chk($sformatf("held rst f%0d", frame_no), observe(), 32'd0);
        rst_n = 1'b1;
        frame_no++;
        return;
      end
    end
    pend_dv = !g && !se && !(pen && pe);
    pend_fe = !g && se;
    pend_pe = !g && pen && pe;
    frame_no++;
  endtask

  initial begin
    bus.rx_in = 1'b1;
    noise();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset", observe(), 32'd0);
    rst_n = 1'b1;
    idle(3);

    run_frame(8, 1'b1, 1'b0, 1'b0, 1'b0, -1);
    idle(2);
    run_frame(16, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    idle(1);
    run_frame(8, 1'b0, 1'b1, 1'b0, 1'b0, -1);
    run_frame(8, 1'b1, 1'b0, 1'b0, 1'b0, -1);
    idle(1);
    run_frame(8, 1'b1, 1'b0, 1'b1, 1'b1, -1);
    run_frame(8, 1'b1, 1'b0, 1'b0, 1'b0, -1);
    idle(2);
    run_frame(8, 1'b0, 1'b0, 1'b0, 1'b0, 4 * 8 + 3);
    idle(4);
    run_frame(8, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    run_frame(5, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    run_frame(5, 1'b1, 1'b0, 1'b1, 1'b0, -1);
    idle(1);

    for (int i = 0; i < 30; i++) begin
      int psc;
      bit pen, g, pe, se;
      psc = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 20));
      pen = 1'($urandom);
      g   = ($urandom_range(0, 5) == 0);
      pe  = 1'($urandom);
      se  = 1'($urandom);
      run_frame(psc, pen, g, pe, se, -1);
      idle(int'($urandom_range(0, 2)));
    end
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
